// File: rtl/hb_regs_pkg.sv
// ============================================================================
// hb_regs_pkg : register map, ID value and handshake state type for the
//               Wishbone heartbeat block.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package hb_regs_pkg;

    localparam logic [7:0]  c_OFF_CTRL   = 8'h00;
    localparam logic [7:0]  c_OFF_DIV    = 8'h04;
    localparam logic [7:0]  c_OFF_COUNT  = 8'h08;
    localparam logic [7:0]  c_OFF_STATUS = 8'h0C;
    localparam logic [7:0]  c_OFF_ID     = 8'h10;

    localparam logic [31:0] c_ID_VALUE   = 32'h4842_0001;

    localparam int          c_CTRL_EN     = 0;
    localparam int          c_CTRL_IRQ_EN = 1;
    localparam int          c_CTRL_CLEAR  = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } hb_state_e;

endpackage

`default_nettype wire

// File: rtl/hb_ticker.sv
// ============================================================================
// hb_ticker : down-counting prescaler that advances a wrapping heartbeat
//             counter on every reload.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module hb_ticker #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 enable_i,
    input  logic                 clear_i,
    input  logic [23:0]          div_i,
    output logic [CNT_WIDTH-1:0] count_o,
    output logic                 wrap_pulse_o
);

    logic [23:0]          pre_q;
    logic [23:0]          pre_d;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    logic                 w_tick;

    assign w_tick = enable_i & (pre_q == 24'd0);

    // Clear overrides a coincident tick, so no wrap is reported in that cycle.
    always_comb begin
        pre_d   = pre_q;
        count_d = count_q;
        if (clear_i) begin
            pre_d   = div_i;
            count_d = '0;
        end else if (w_tick) begin
            pre_d   = div_i;
            count_d = count_q + CNT_WIDTH'(1);
        end else if (enable_i) begin
            pre_d   = pre_q - 24'd1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pre_q   <= 24'd0;
            count_q <= '0;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign wrap_pulse_o = w_tick & ~clear_i & (&count_q);

endmodule

`default_nettype wire

// File: rtl/wb_heartbeat_regs.sv
// ============================================================================
// wb_heartbeat_regs : Wishbone classic slave exposing a programmable
//                     heartbeat counter with wrap flag and level interrupt.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module wb_heartbeat_regs #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          CNT_WIDTH = 8,
    parameter logic [23:0] DIV_RESET = 24'd0
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        hb_out,
    output logic        irq
);

    import hb_regs_pkg::*;

    hb_state_e            state_q;
    logic                 ack_q;
    logic [31:0]          dat_q;

    logic                 en_q;
    logic                 en_d;
    logic                 irq_en_q;
    logic                 irq_en_d;
    logic                 clear_q;
    logic                 clear_d;
    logic                 wrap_q;
    logic                 wrap_d;
    logic [23:0]          div_q;
    logic [23:0]          div_d;

    logic                 w_in_window;
    logic                 w_req;
    logic                 w_wr;
    logic [7:0]           w_off;
    logic [31:0]          w_rdata;
    logic [31:0]          w_count32;
    logic [CNT_WIDTH-1:0] w_count;
    logic                 w_wrap_pulse;
    logic                 w_unused;

    assign w_in_window = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_off       = {wbs_adr_i[7:2], 2'b00};
    assign w_req       = wbs_cyc_i & wbs_stb_i & w_in_window & (state_q == ST_IDLE);
    assign w_wr        = w_req & wbs_we_i;
    assign w_unused    = ^{wbs_adr_i[1:0], wbs_sel_i[3], wbs_dat_i[31:24]};

    hb_ticker #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_ticker (
        .clk          (clk),
        .nreset       (nreset),
        .enable_i     (en_q),
        .clear_i      (clear_q),
        .div_i        (div_q),
        .count_o      (w_count),
        .wrap_pulse_o (w_wrap_pulse)
    );

    generate
        if (CNT_WIDTH < 32) begin : g_cnt_pad
            assign w_count32 = {{(32-CNT_WIDTH){1'b0}}, w_count};
        end else begin : g_cnt_full
            assign w_count32 = w_count;
        end
    endgenerate

    always_comb begin
        w_rdata = '0;
        case (w_off)
            c_OFF_CTRL: begin
                w_rdata[c_CTRL_EN]     = en_q;
                w_rdata[c_CTRL_IRQ_EN] = irq_en_q;
            end
            c_OFF_DIV:    w_rdata[23:0] = div_q;
            c_OFF_COUNT:  w_rdata       = w_count32;
            c_OFF_STATUS: w_rdata[0]    = wrap_q;
            c_OFF_ID:     w_rdata       = c_ID_VALUE;
            default:      w_rdata       = '0;
        endcase
    end

    // A wrap arriving with a W1C of STATUS must survive, hence the set is applied last.
    always_comb begin
        en_d     = en_q;
        irq_en_d = irq_en_q;
        clear_d  = 1'b0;
        div_d    = div_q;
        wrap_d   = wrap_q;
        if (w_wr) begin
            case (w_off)
                c_OFF_CTRL: begin
                    if (wbs_sel_i[0]) begin
                        en_d     = wbs_dat_i[c_CTRL_EN];
                        irq_en_d = wbs_dat_i[c_CTRL_IRQ_EN];
                        clear_d  = wbs_dat_i[c_CTRL_CLEAR];
                    end
                end
                c_OFF_DIV: begin
                    if (wbs_sel_i[0]) div_d[7:0]   = wbs_dat_i[7:0];
                    if (wbs_sel_i[1]) div_d[15:8]  = wbs_dat_i[15:8];
                    if (wbs_sel_i[2]) div_d[23:16] = wbs_dat_i[23:16];
                end
                c_OFF_STATUS: begin
                    if (wbs_sel_i[0] && wbs_dat_i[0]) wrap_d = 1'b0;
                end
                default: begin
                end
            endcase
        end
        if (w_wrap_pulse) wrap_d = 1'b1;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            en_q     <= 1'b0;
            irq_en_q <= 1'b0;
            clear_q  <= 1'b0;
            wrap_q   <= 1'b0;
            div_q    <= DIV_RESET;
        end else begin
            en_q     <= en_d;
            irq_en_q <= irq_en_d;
            clear_q  <= clear_d;
            wrap_q   <= wrap_d;
            div_q    <= div_d;
        end
    end

    // Handshake: sample in IDLE, acknowledge for one cycle, always return to IDLE.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_req) begin
                        state_q <= ST_ACK;
                        ack_q   <= 1'b1;
                        dat_q   <= wbs_we_i ? 32'd0 : w_rdata;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                    dat_q   <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                    dat_q   <= '0;
                end
            endcase
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign hb_out    = w_count[CNT_WIDTH-1];
    assign irq       = wrap_q & irq_en_q;

endmodule

`default_nettype wire
